// File: rtl/nf_dbg_pkg.sv
// nf_dbg_pkg: shared key FSM states and default debounce/repeat timing for the debug scan controller
package nf_dbg_pkg;
  localparam int DB_CYCLES_DEF = 500000;
  localparam int REP_CYCLES_DEF = 25000000;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;
endpackage

// File: rtl/nf_key_debounce.sv
// nf_key_debounce: one key (clk, reset, key_n active-low raw -> db level, stb one-cycle press/repeat strobe)
module nf_key_debounce
  import nf_dbg_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int REP_CYCLES = REP_CYCLES_DEF,
  parameter bit REPEAT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic db,
  output logic stb
);
  localparam int DW = $clog2(DB_CYCLES) + 1;
  localparam int RW = $clog2(REP_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES > 2 ? DB_CYCLES - 2 : 0);
  localparam logic [RW-1:0] REP_LAST = RW'(REP_CYCLES - 1);
  logic [1:0] sync;
  logic k;
  key_state_t state;
  logic [DW-1:0] cnt, cnt_inc;
  logic [RW-1:0] rcnt, rcnt_inc;
  assign k = sync[1];
  assign cnt_inc = &cnt ? cnt : cnt + DW'(1);
  assign rcnt_inc = &rcnt ? rcnt : rcnt + RW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      state <= IDLE;
      cnt <= '0;
      rcnt <= '0;
      db <= 1'b0;
      stb <= 1'b0;
    end else begin
      sync <= {sync[0], ~key_n};
      stb <= 1'b0;
      case (state)
        IDLE: if (k) begin
          state <= PRESS_WAIT;
          cnt <= '0;
        end
        PRESS_WAIT: if (!k) state <= IDLE;
          else if (cnt >= DB_LAST) begin
            state <= HELD;
            db <= 1'b1;
            stb <= 1'b1;
            rcnt <= '0;
          end else cnt <= cnt_inc;
        HELD: if (!k) begin
          state <= RELEASE_WAIT;
          cnt <= '0;
          rcnt <= '0;
        end else if (REPEAT && rcnt >= REP_LAST) begin
          stb <= 1'b1;
          rcnt <= '0;
        end else rcnt <= rcnt_inc;
        RELEASE_WAIT: if (k) state <= HELD;
          else if (cnt >= DB_LAST) begin
            state <= IDLE;
            db <= 1'b0;
          end else cnt <= cnt_inc;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/nf_dbg_scan_ctrl.sv
// nf_dbg_scan_ctrl: 4-key debug scan stepper (clk, reset, key[3:0] active-low -> reg_addr, key_db, key_stb, freeze)
module nf_dbg_scan_ctrl
  import nf_dbg_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int REP_CYCLES = REP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  output logic [4:0] reg_addr,
  output logic [3:0] key_db,
  output logic [3:0] key_stb,
  output logic       freeze
);
  for (genvar i = 0; i < 4; i++) begin : g_key
    nf_key_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .REP_CYCLES(REP_CYCLES),
      .REPEAT(i < 2)
    ) u_key (
      .clk(clk),
      .reset(reset),
      .key_n(key[i]),
      .db(key_db[i]),
      .stb(key_stb[i])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_addr <= '0;
      freeze <= 1'b0;
    end else begin
      if (key_stb[2]) reg_addr <= '0;
      else if (!freeze && (key_stb[0] ^ key_stb[1])) reg_addr <= key_stb[0] ? reg_addr + 5'd1 : reg_addr - 5'd1;
      if (key_stb[3]) freeze <= ~freeze;
    end
  end
endmodule

// File: tb/tb_nf_dbg_scan_ctrl.sv
// tb_nf_dbg_scan_ctrl: table-driven scoreboard bench for nf_dbg_scan_ctrl with DB_CYCLES=4, REP_CYCLES=16
module tb_nf_dbg_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] key = 4'hF;
  logic [4:0] reg_addr;
  logic [3:0] key_db, key_stb;
  logic freeze;
  nf_dbg_scan_ctrl #(.DB_CYCLES(4), .REP_CYCLES(16)) dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .reg_addr(reg_addr),
    .key_db(key_db),
    .key_stb(key_stb),
    .freeze(freeze)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] stb;
    logic [4:0] addr;
    logic       frz;
  } exp_t;
  typedef struct {
    logic [3:0] press;
    int         hold;
    int         n;
    logic [4:0] a0;
    int         d;
    logic       frz;
  } vec_t;
  exp_t sbq[$];
  exp_t ex, e;
  vec_t tbl[14];
  int errs = 0;
  int checks = 0;
  int n;
  logic seen;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic press(input logic [3:0] p, input int hold);
    @(posedge clk);
    #1 key = ~p;
    repeat (hold) @(posedge clk);
    #1 key = 4'hF;
    repeat (12) @(posedge clk);
  endtask
  task automatic wait_stb0(output int cnt);
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      cnt++;
      #1;
      if (key_stb[0]) break;
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (!reset && key_stb != 4'd0) begin
      if (sbq.size() == 0) chk("unexpected_stb", int'(key_stb), 0);
      else begin
        e = sbq.pop_front();
        chk("stb", int'(key_stb), int'(e.stb));
        @(negedge clk);
        chk("addr", int'(reg_addr), int'(e.addr));
        chk("freeze", int'(freeze), int'(e.frz));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{4'b0001, 10, 1, 5'd2, 0, 1'b0};
    tbl[1]  = '{4'b0100, 40, 1, 5'd0, 0, 1'b0};
    tbl[2]  = '{4'b0010, 40, 3, 5'd31, -1, 1'b0};
    tbl[3]  = '{4'b0100, 10, 1, 5'd0, 0, 1'b0};
    tbl[4]  = '{4'b0001, 104, 7, 5'd1, 1, 1'b0};
    tbl[5]  = '{4'b0101, 10, 1, 5'd0, 0, 1'b0};
    tbl[6]  = '{4'b0001, 72, 5, 5'd1, 1, 1'b0};
    tbl[7]  = '{4'b0011, 10, 1, 5'd5, 0, 1'b0};
    tbl[8]  = '{4'b1000, 40, 1, 5'd5, 0, 1'b1};
    tbl[9]  = '{4'b0001, 10, 1, 5'd5, 0, 1'b1};
    tbl[10] = '{4'b0010, 10, 1, 5'd5, 0, 1'b1};
    tbl[11] = '{4'b0100, 10, 1, 5'd0, 0, 1'b1};
    tbl[12] = '{4'b1000, 10, 1, 5'd0, 0, 1'b0};
    tbl[13] = '{4'b0001, 10, 1, 5'd1, 0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", int'(reg_addr), 0);
    chk("rst_db", int'(key_db), 0);
    chk("rst_stb", int'(key_stb), 0);
    chk("rst_freeze", int'(freeze), 0);
    reset = 1'b0;
    seen = 1'b0;
    @(posedge clk);
    #1 key = 4'b1110;
    repeat (3) @(posedge clk);
    #1 key = 4'hF;
    repeat (12) begin
      @(posedge clk);
      #1 if (key_db != 4'd0) seen = 1'b1;
    end
    chk("glitch_db", int'(seen), 0);
    chk("glitch_addr", int'(reg_addr), 0);
    ex = '{4'b0001, 5'd1, 1'b0};
    sbq.push_back(ex);
    @(posedge clk);
    #1 key = 4'b1110;
    wait_stb0(n);
    chk("press_latency", n, 6);
    repeat (10 - n) @(posedge clk);
    #1 key = 4'hF;
    repeat (12) @(posedge clk);
    chk("first_press_done", sbq.size(), 0);
    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        ex.stb = (k == 0) ? tbl[r].press : (tbl[r].press & 4'b0011);
        ex.addr = 5'(int'(tbl[r].a0) + tbl[r].d * k);
        ex.frz = tbl[r].frz;
        sbq.push_back(ex);
      end
      press(tbl[r].press, tbl[r].hold);
      chk($sformatf("row%0d_done", r), sbq.size(), 0);
    end
    @(posedge clk);
    #1 key = 4'b1110;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_addr", int'(reg_addr), 0);
    chk("midrst_db", int'(key_db), 0);
    chk("midrst_stb", int'(key_stb), 0);
    chk("midrst_freeze", int'(freeze), 0);
    ex = '{4'b0001, 5'd1, 1'b0};
    sbq.push_back(ex);
    wait_stb0(n);
    chk("rst_relatency", n, 6);
    repeat (4) @(posedge clk);
    #1 key = 4'hF;
    repeat (12) @(posedge clk);
    chk("rst_press_done", sbq.size(), 0);
    chk("final_addr", int'(reg_addr), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
